// File: rtl/pixel_fb_writer.sv
// Pixel-stream sink: FIFO-buffers drawer pixels and writes them to a linear framebuffer,
// with a colour-fill clear sweep. Define PIXEL_FB_CLIP_EN to discard off-screen pixels.
module pixel_fb_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int COORD_W    = 8,
  parameter int COLOR_W    = 24,
  parameter int FB_XMAX    = 255,
  parameter int FB_YMAX    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pixel_valid,
  input  logic [COORD_W-1:0]            px,
  input  logic [COORD_W-1:0]            py,
  input  logic [COLOR_W-1:0]            pixel_color,
  input  logic                          draw_done,
  input  logic                          clear_start,
  input  logic [COLOR_W-1:0]            clear_color,
  output logic                          mem_wr_valid,
  output logic [2*COORD_W-1:0]          mem_addr,
  output logic [COLOR_W-1:0]            mem_wr_data,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ADDR_W = 2 * COORD_W;
  localparam int ENT_W  = ADDR_W + COLOR_W;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      FB_XMAX >= (1 << COORD_W) || FB_YMAX >= (1 << COORD_W)) begin : g_bad_param
    $error("pixel_fb_writer: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_CLEAR = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [ENT_W-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [COLOR_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;
  logic                 pending_q, pending_d;
  logic                 draw_done_q, overflow_q;

  logic                 accept_s, full_s, empty_s, push_s, pop_s, drop_s;
  logic                 done_rise_s, clr_hs_s, clr_last_s;
  logic [ADDR_W-1:0]    clr_next_s, head_addr_s;
  logic [COLOR_W-1:0]   head_color_s;

`ifdef PIXEL_FB_CLIP_EN
  localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(FB_XMAX);
  localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(FB_YMAX);
  localparam logic [COORD_W-1:0] CRD_ONE = COORD_W'(1);
  assign accept_s = (px <= XMAX_C) && (py <= YMAX_C);
`else
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  assign accept_s = 1'b1;
`endif

  assign full_s       = (count_q == LVL_FULL);
  assign empty_s      = (count_q == LVL_ZERO);
  assign pop_s        = (state_q == S_WRITE) && mem_wr_valid_q && mem_ready;
  // A full FIFO still takes a pixel when the head retires in the same cycle.
  assign push_s       = pixel_valid && accept_s && (!full_s || pop_s);
  assign drop_s       = pixel_valid && accept_s && full_s && !pop_s;
  assign done_rise_s  = draw_done && !draw_done_q;
  assign clr_hs_s     = (state_q == S_CLEAR) && mem_ready;
  assign head_addr_s  = fifo_mem_q[rd_ptr_q][ENT_W-1:COLOR_W];
  assign head_color_s = fifo_mem_q[rd_ptr_q][COLOR_W-1:0];

  // Clear-sweep address successor and end-of-sweep detection.
  always_comb begin
    clr_next_s = mem_addr_q;
    clr_last_s = 1'b0;
`ifdef PIXEL_FB_CLIP_EN
    clr_last_s = (mem_addr_q[COORD_W-1:0] == XMAX_C) && (mem_addr_q[ADDR_W-1:COORD_W] == YMAX_C);
    if (mem_addr_q[COORD_W-1:0] == XMAX_C) begin
      clr_next_s = {mem_addr_q[ADDR_W-1:COORD_W] + CRD_ONE, {COORD_W{1'b0}}};
    end else begin
      clr_next_s = {mem_addr_q[ADDR_W-1:COORD_W], mem_addr_q[COORD_W-1:0] + CRD_ONE};
    end
`else
    clr_last_s = (mem_addr_q == ADDR_MAX);
    clr_next_s = mem_addr_q + ADDR_ONE;
`endif
  end

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LVL_ONE;
      2'b01:   count_d = count_q - LVL_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {py, px, pixel_color};
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= LVL_ZERO;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q    <= count_d;
      overflow_q <= overflow_q | drop_s;
    end
  end

  // State register plus registered outputs and done tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mem_wr_valid_q <= 1'b0;
      mem_addr_q     <= {ADDR_W{1'b0}};
      mem_wr_data_q  <= {COLOR_W{1'b0}};
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      pending_q      <= 1'b0;
      draw_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
      pending_q      <= pending_d;
      draw_done_q    <= draw_done;
    end
  end

  // Next-state logic; draining the FIFO outranks a clear request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s)         state_d = S_WRITE;
        else if (clear_start) state_d = S_CLEAR;
        else                  state_d = S_IDLE;
      end
      S_WRITE: begin
        if (pop_s) state_d = S_IDLE;
        else       state_d = S_WRITE;
      end
      S_CLEAR: begin
        if (clr_hs_s && clr_last_s) state_d = S_IDLE;
        else                        state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values for the write port, frame_done and busy.
  always_comb begin
    mem_wr_valid_d = mem_wr_valid_q;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          mem_wr_valid_d = 1'b1;
          mem_addr_d     = head_addr_s;
          mem_wr_data_d  = head_color_s;
        end else if (clear_start) begin
          mem_wr_valid_d = 1'b1;
          mem_addr_d     = {ADDR_W{1'b0}};
          mem_wr_data_d  = clear_color;
        end else begin
          mem_wr_valid_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (pop_s) mem_wr_valid_d = 1'b0;
        else       mem_wr_valid_d = mem_wr_valid_q;
      end
      S_CLEAR: begin
        if (clr_hs_s && clr_last_s) mem_wr_valid_d = 1'b0;
        else if (clr_hs_s)          mem_addr_d     = clr_next_s;
        else                        mem_addr_d     = mem_addr_q;
      end
      default: mem_wr_valid_d = 1'b0;
    endcase
    frame_done_d = pending_q && (state_q == S_IDLE) && empty_s;
    pending_d    = frame_done_d ? 1'b0 : (pending_q | done_rise_s);
    busy_d       = (state_d != S_IDLE) || (count_d != LVL_ZERO);
  end

  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;
  assign fifo_level   = count_q;
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: single write, overflow burst, frame_done,
// full clear sweep with mid-sweep pixel, asynchronous reset, and optional clipping.
module tb_pixel_fb_writer;
  localparam int CW = 8, COLW = 24, DEPTH = 16, XMAX = 159, YMAX = 255;
`ifdef PIXEL_FB_CLIP_EN
  localparam int CLR_TOTAL = (XMAX + 1) * (YMAX + 1);
  localparam int SWEEP_XMAX = XMAX;
`else
  localparam int CLR_TOTAL = 65536;
  localparam int SWEEP_XMAX = 255;
`endif

  logic            clk = 1'b0, rst = 1'b1;
  logic            pixel_valid = 1'b0, draw_done = 1'b0, clear_start = 1'b0, mem_ready = 1'b0;
  logic [CW-1:0]   px = 8'd0, py = 8'd0;
  logic [COLW-1:0] pixel_color = 24'd0, clear_color = 24'd0;
  logic            mem_wr_valid, busy, frame_done, overflow;
  logic [2*CW-1:0] mem_addr;
  logic [COLW-1:0] mem_wr_data;
  logic [4:0]      fifo_level;

  pixel_fb_writer #(.FIFO_DEPTH(DEPTH), .COORD_W(CW), .COLOR_W(COLW),
                    .FB_XMAX(XMAX), .FB_YMAX(YMAX)) dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .px(px), .py(py),
    .pixel_color(pixel_color), .draw_done(draw_done), .clear_start(clear_start),
    .clear_color(clear_color), .mem_wr_valid(mem_wr_valid), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_ready(mem_ready), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [39:0] wr_q[$];
  int  fd_count = 0, clr_idx = 0, clr_bad = 0, ex = 0, ey = 0;
  time fd_time = 0, last_hs_time = 0;
  bit  clr_mon = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
    pixel_valid = 1'b1; px = x; py = y; pixel_color = c;
    tick();
    pixel_valid = 1'b0;
  endtask

  // Handshake and frame_done monitor; the clear sweep is checked against an x/y model.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && mem_wr_valid && mem_ready) begin
        last_hs_time = $time;
        if (clr_mon) begin
          if (clr_idx < CLR_TOTAL) begin
            if (mem_addr !== {ey[7:0], ex[7:0]} || mem_wr_data !== 24'hF5DEB3) clr_bad++;
            if (ex == SWEEP_XMAX) begin ex = 0; ey++; end
            else ex++;
          end else if (mem_addr !== 16'h0705 || mem_wr_data !== 24'h123456) begin
            clr_bad++;
          end
          clr_idx++;
        end else begin
          wr_q.push_back({mem_addr, mem_wr_data});
        end
      end
      if (!rst && frame_done) begin
        fd_count++;
        fd_time = $time;
      end
    end
  end

  logic [7:0] cx[8] = '{8'd50, 8'd30, 8'd40, 8'd40, 8'd47, 8'd33, 8'd47, 8'd33};
  logic [7:0] cy[8] = '{8'd40, 8'd40, 8'd50, 8'd30, 8'd47, 8'd47, 8'd33, 8'd33};

  initial begin
    int n_fd, n_wr;
    logic [39:0] e;
    tick(); tick();
    check("rst_valid", mem_wr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_ovf", {overflow, frame_done}, 2'b00);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();

    // Single pixel: visible two edges after the sample.
    pixel_valid = 1'b1; px = 8'd224; py = 8'd32; pixel_color = 24'h00FF00;
    tick();
    pixel_valid = 1'b0;
    check("single_level1", fifo_level, 5'd1);
    check("single_novalid_yet", mem_wr_valid, 1'b0);
    tick();
    check("single_valid", mem_wr_valid, 1'b1);
    check("single_addr", mem_addr, 16'h20E0);
    check("single_data", mem_wr_data, 24'h00FF00);
    repeat (4) tick();
    check("single_count", wr_q.size(), 1);
    check("single_idle", {busy, fifo_level}, 6'd0);

    // Burst of 20 with the port stalled.
    wr_q.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pixel_valid = 1'b1; px = i[7:0]; py = 8'h30; pixel_color = 24'hA00000 + i[23:0];
      tick();
    end
    pixel_valid = 1'b0;
    check("burst_level", fifo_level, 5'd16);
    check("burst_ovf", overflow, 1'b1);
    check("burst_head", {mem_wr_valid, mem_addr}, {1'b1, 16'h3000});
    mem_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin tick(); if (!busy) break; end
    check("burst_drained", busy, 1'b0);
    check("burst_count", wr_q.size(), 16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      e = wr_q[i];
      check("burst_order", e, {8'h30, i[7:0], 24'hA00000 + i[23:0]});
    end

    // Shape stream, done edges (second one absorbed), port toggling.
    wr_q.delete();
    fd_count = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(cx[i], cy[i], 24'hFF00FF);
    draw_done = 1'b1; tick();
    draw_done = 1'b0; tick();
    draw_done = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      mem_ready = ~mem_ready;
      if (!busy && fd_count > 0) break;
    end
    repeat (5) tick();
    check("shape_count", wr_q.size(), 8);
    check("shape_fd_once", fd_count, 1);
    check("shape_fd_after", fd_time > last_hs_time, 1'b1);
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      e = wr_q[i];
      check("shape_pix", e, {cy[i], cx[i], 24'hFF00FF});
    end

    // Full clear with a pixel injected mid-sweep.
    mem_ready = 1'b1;
    clr_mon = 1'b1;
    clear_color = 24'hF5DEB3;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr_start", {busy, mem_wr_valid, mem_addr, mem_wr_data}, {2'b11, 16'h0000, 24'hF5DEB3});
    for (int c = 0; c < 70000; c++) begin
      tick();
      if (c == 100) begin pixel_valid = 1'b1; px = 8'd5; py = 8'd7; pixel_color = 24'h123456; end
      if (c == 101) pixel_valid = 1'b0;
      if (c > 101 && !busy) break;
    end
    check("clr_done", {busy, mem_wr_valid}, 2'b00);
    check("clr_writes", clr_idx, CLR_TOTAL + 1);
    check("clr_order", clr_bad, 0);
    clr_mon = 1'b0;

    // Asynchronous reset while a write is stalled with done pending.
    draw_done = 1'b0;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) send(8'd1, i[7:0], 24'h0000FF);
    tick();
    draw_done = 1'b1;
    tick();
    check("pre_rst_valid", {mem_wr_valid, busy}, 2'b11);
    #3;
    rst = 1'b1;
    draw_done = 1'b0;
    #1;
    check("arst_outs", {mem_wr_valid, busy, overflow, frame_done}, 4'b0000);
    check("arst_level", fifo_level, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_fd = fd_count;
    n_wr = wr_q.size();
    mem_ready = 1'b1;
    repeat (10) tick();
    check("arst_no_fd", fd_count, n_fd);
    check("arst_no_wr", wr_q.size(), n_wr);

`ifdef PIXEL_FB_CLIP_EN
    send(8'd200, 8'd3, 24'h0000AA);
    repeat (5) tick();
    check("clip_drop", wr_q.size(), n_wr);
    check("clip_noovf", overflow, 1'b0);
    send(8'd159, 8'd3, 24'h0000AA);
    repeat (5) tick();
    check("clip_keep", wr_q.size(), n_wr + 1);
    if (wr_q.size() > n_wr) check("clip_addr", wr_q[n_wr], {8'd3, 8'd159, 24'h0000AA});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sink end of the shape-drawer pixel stream (pixel_valid / px / py / pixel_color / done).
- Buffers incoming pixels in an internal FIFO and writes each one into a linear framebuffer RAM through a valid/ready write port.
- Also performs a full-framebuffer clear with a programmable colour.
- Reports frame completion once the drawer's done has been seen and every buffered pixel has been committed.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4.
- COORD_W, 8, width of the x and y coordinates.
- COLOR_W, 24, pixel colour width (RGB888).
- FB_XMAX, 255, largest x coordinate accepted when clipping is compiled in.
- FB_YMAX, 255, largest y coordinate accepted when clipping is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pixel_valid  in  1  the pixel on px/py/pixel_color is valid this cycle; there is no backpressure.
- px  in  COORD_W  pixel x coordinate.
- py  in  COORD_W  pixel y coordinate.
- pixel_color  in  COLOR_W  pixel colour.
- draw_done  in  1  drawer done level; its rising edge marks the end of a shape.
- clear_start  in  1  one-cycle pulse that requests a framebuffer clear.
- clear_color  in  COLOR_W  clear colour, sampled when clear_start is accepted.
- mem_wr_valid  out  1  write request to the framebuffer.
- mem_addr  out  2*COORD_W  write address, equal to {y, x}.
- mem_wr_data  out  COLOR_W  write data.
- mem_ready  in  1  the framebuffer accepts the write when mem_wr_valid && mem_ready.
- busy  out  1  high when the state is not IDLE, or the FIFO is not empty.
- frame_done  out  1  one-cycle pulse when a shape is fully committed.
- overflow  out  1  sticky; set when a pixel arrives while the FIFO is full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, immediate): all outputs 0, FIFO empty, state IDLE, draw_done edge detector cleared.
- FIFO input:
  - A pixel is pushed on every cycle with pixel_valid=1 and the FIFO not full.
  - If the FIFO is full, the pixel is dropped, overflow is set, and overflow stays set until rst.
  - A push and a pop in the same cycle leave fifo_level unchanged, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
- State IDLE:
  - If the FIFO is not empty, load the head entry onto mem_addr/mem_wr_data, assert mem_wr_valid, and go to WRITE.
  - Otherwise, if clear_start is high, latch clear_color and go to CLEAR.
- State WRITE:
  - mem_wr_valid, mem_addr and mem_wr_data stay constant until mem_ready is sampled high.
  - On handshake the FIFO is popped. If another entry is present it is presented on the next cycle (one idle cycle between writes). Otherwise go to IDLE.
- State CLEAR:
  - Sweep addresses 0 to 2^(2*COORD_W)-1, one address per handshake, holding mem_wr_valid high throughout.
  - After the last address is accepted, go to IDLE.
  - During CLEAR, incoming pixels are still pushed into the FIFO and drain afterwards.
  - clear_start is ignored outside IDLE.
  - If the FIFO is non-empty in IDLE, draining takes priority over clear_start; a clear_start pulse that loses this arbitration is dropped, not queued.
- Done tracking:
  - A draw_done rising edge sets a pending flag.
  - frame_done pulses for exactly one cycle on the first cycle where pending=1, state is IDLE and the FIFO is empty; pending is then cleared.
  - A second rising edge while pending is already set is absorbed: only one pulse is produced.
- Latency: from a pixel_valid sample with FIFO empty and the block IDLE, mem_wr_valid rises 2 cycles later (cycle 1 push, cycle 2 present).
- Reset mid-operation: any in-flight write, clear sweep or pending done is abandoned; the FIFO contents are lost.

Optional Feature:
- Macro: PIXEL_FB_CLIP_EN.
- When defined, pixels with px>FB_XMAX or py>FB_YMAX are discarded before the FIFO. They never set overflow, and the CLEAR sweep covers only x<=FB_XMAX, y<=FB_YMAX (row-major, y outer).
- When undefined, every pixel is accepted and CLEAR covers the full address space.

Test Plan:
- Single pixel (px=224, py=32, color=00FF00), mem_ready tied high -> mem_wr_valid 2 cycles later, mem_addr=16'h20E0, data=00FF00, one write only.
- Burst of 20 back-to-back pixels with mem_ready=0, FIFO_DEPTH=16 -> fifo_level=16, overflow=1, exactly 16 writes after mem_ready rises, in arrival order.
- Pixel stream (xc=40, yc=40, r=10, color FF00FF), then draw_done high, with mem_ready toggling every other cycle -> every pixel written once, frame_done pulses once and only after the last handshake.
- clear_start with clear_color=F5DEB3, mem_ready=1 -> 65536 writes, addresses 0 to FFFF in order, then busy=0. A pixel injected mid-clear is written after the sweep ends.
- rst asserted during WRITE with mem_ready=0 -> mem_wr_valid, busy, fifo_level and overflow go to 0 without waiting for clk, and no frame_done follows.
- With PIXEL_FB_CLIP_EN, FB_XMAX=159: pixel px=200 -> no write and no overflow; pixel px=159 -> written.
